// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: default widths, source ids and request type for the writeback arbiter
package wb_arb_pkg;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;
    localparam int CNT_W_DEF = 16;
    typedef enum logic {SRC_MEM = 1'b0, SRC_EX = 1'b1} src_e;
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: source handshakes, register-file write port and hazard query of wb_arbiter
interface wb_arbiter_if import wb_arb_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             s0_valid;
    logic             s0_ready;
    logic [AW-1:0]    s0_addr;
    logic [DW-1:0]    s0_data;
    logic             s1_valid;
    logic             s1_ready;
    logic [AW-1:0]    s1_addr;
    logic [DW-1:0]    s1_data;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic [AW-1:0]    q_addr1;
    logic [AW-1:0]    q_addr2;
    logic             q_hit1;
    logic             q_hit2;
    logic [CNT_W-1:0] conflict_cnt;
    modport master (
        output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data, q_addr1, q_addr2,
        input  s0_ready, s1_ready, rf_we, rf_waddr, rf_wdata, q_hit1, q_hit2, conflict_cnt
    );
    modport slave (
        input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data, q_addr1, q_addr2,
        output s0_ready, s1_ready, rf_we, rf_waddr, rf_wdata, q_hit1, q_hit2, conflict_cnt
    );
endinterface

// File: rtl/wb_arb_slot.sv
// wb_arb_slot: one-entry writeback holding register; accepts while empty or while draining
module wb_arb_slot import wb_arb_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic          drain,
    output logic          ready,
    output logic          v,
    output logic [AW-1:0] slot_addr,
    output logic [DW-1:0] slot_data
);
    assign ready = !rst && (!v || drain);
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
        end else if (valid && ready) begin
            v <= 1'b1;
            slot_addr <= addr;
            slot_data <= data;
        end else if (drain) begin
            v <= 1'b0;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-source register-file writeback arbiter with hazard lookup and contention counter.
// Define WB_ARB_RR_EN for round-robin contention; otherwise the memory source always wins.
module wb_arbiter import wb_arb_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    logic [1:0]    sv;
    logic [AW-1:0] sa [2];
    logic [DW-1:0] sd [2];
    logic          gv;
    src_e          g;
    assign gv = |sv;
    wb_arb_slot #(.AW(AW), .DW(DW)) u_slot0 (
        .clk(clk), .rst(rst), .valid(bus.s0_valid), .addr(bus.s0_addr), .data(bus.s0_data),
        .drain(gv && g == SRC_MEM), .ready(bus.s0_ready), .v(sv[0]),
        .slot_addr(sa[0]), .slot_data(sd[0])
    );
    wb_arb_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .clk(clk), .rst(rst), .valid(bus.s1_valid), .addr(bus.s1_addr), .data(bus.s1_data),
        .drain(gv && g == SRC_EX), .ready(bus.s1_ready), .v(sv[1]),
        .slot_addr(sa[1]), .slot_data(sd[1])
    );
`ifdef WB_ARB_RR_EN
    logic last_grant;
    assign g = src_e'(&sv ? !last_grant : !sv[0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gv) begin
            last_grant <= g;
        end
    end
`else
    assign g = src_e'(!sv[0]);
`endif
    // a register is busy while it sits in a slot or is on the write port this cycle
    function automatic logic hit(input logic [AW-1:0] q);
        return !rst && q != '0 && ((sv[0] && sa[0] == q) || (sv[1] && sa[1] == q) ||
                                   (bus.rf_we && bus.rf_waddr == q));
    endfunction
    assign bus.q_hit1 = hit(bus.q_addr1);
    assign bus.q_hit2 = hit(bus.q_addr2);
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rf_we <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.conflict_cnt <= '0;
        end else begin
            bus.rf_we <= gv && sa[g] != '0;
            if (gv) begin
                bus.rf_waddr <= sa[g];
                bus.rf_wdata <= sd[g];
            end
            if (&sv && !(&bus.conflict_cnt)) begin
                bus.conflict_cnt <= bus.conflict_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the integer register file's single write port between two writeback sources: source 0 is the memory/load unit and source 1 is the execute unit. Each source hands its write over with a valid/ready handshake into a one-entry holding slot. The block arbitrates between the slots and drives a registered write port (`rf_we`/`rf_waddr`/`rf_wdata`) that connects directly to the register file's write port. It also exports pending-write hit signals for the decode-stage hazard/stall logic.

## Interface
Parameters:
- `AW`, 5, register address width
- `DW`, 32, data width
- `CNT_W`, 16, conflict counter width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `s0_valid` / `s1_valid`  in  1  source presents a write
- `s0_ready` / `s1_ready`  out  1  slot can accept this cycle
- `s0_addr` / `s1_addr`  in  AW  destination register
- `s0_data` / `s1_data`  in  DW  write data
- `rf_we`  out  1  register file write enable (registered)
- `rf_waddr`  out  AW  register file write address (registered)
- `rf_wdata`  out  DW  register file write data (registered)
- `q_addr1` / `q_addr2`  in  AW  hazard query addresses (decode rs1/rs2)
- `q_hit1` / `q_hit2`  out  1  a write to this non-zero address is pending
- `conflict_cnt`  out  CNT_W  saturating count of cycles in which both slots were valid

## Operation
- Per-source slot state: `slot_v`, `slot_addr`, `slot_data`.
- Transfer on source s happens when `sN_valid && sN_ready`. The slot loads on that clock edge.
- Ready: `sN_ready = !rst && (!slot_v[N] || grant==N)`. A slot can be refilled in the same cycle it drains.
- Arbitration is combinational over `slot_v` and yields a grant index:
  - Only one slot valid: that slot is granted.
  - Both slots valid: fixed priority, source 0 wins.
  - No slot valid: no grant.
- Every edge:
  - `rf_we <= granted && slot_addr[g] != 0`.
  - When granted, `rf_waddr`/`rf_wdata` load from slot g. When not granted, they hold their previous values.
  - `slot_v[g]` clears unless the slot is refilled in the same cycle.
- x0 writes: accepted and consumed normally, but never produce `rf_we=1`.
- Same address in both slots: writes land in grant order, so the last-granted value persists. Ordering between sources is the pipeline's responsibility.
- `q_hitK = (q_addrK != 0)` and (a valid slot holds `q_addrK`, or `rf_we && rf_waddr == q_addrK`). This is purely combinational.
- `conflict_cnt` increments when both `slot_v` bits are 1 and saturates at all-ones.
- Reset value of every output:
  - `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `conflict_cnt=0`.
  - `s0_ready`/`s1_ready=0` while `rst` is high.
  - `q_hit1`/`q_hit2=0`.
- Reset mid-operation: both slots are discarded with no write issued, and the round-robin pointer returns to its reset value.

## Timing
- Accept at edge N, so the slot is valid after N.
- Earliest `rf_we=1` is in the cycle after edge N+1. The register file is updated at edge N+2.
- Throughput: one register-file write per cycle. A source that streams while the other is idle sustains 1 transfer per cycle.
- Under fixed priority, source 1 can be stalled indefinitely while source 0 streams. Its `s1_ready` stays 0 for as long as its slot is full and not granted.
- `sN_ready` depends combinationally on `slot_v` and the grant only. It never depends on `sN_valid`.

## Configuration
- `WB_ARB_RR_EN` defined:
  - Adds a `last_grant` register, reset value 1.
  - When both slots are valid, grant goes to `!last_grant`.
  - `last_grant` updates on every grant.
  - Result: with continuous contention the grants alternate 0,1,0,1…, and each source waits at most one cycle behind the other.
- `WB_ARB_RR_EN` undefined: fixed priority, source 0 always wins contention, and no `last_grant` register exists.

## Structure
- Package `wb_arb_pkg`:
  - Default `AW`/`DW`/`CNT_W` constants.
  - Source enum `SRC_MEM=0`, `SRC_EX=1`.
  - Typedef `wb_req_t` with fields `addr` and `data`.
- Sub-module `wb_arb_slot`: the one-entry holding register with its valid/ready logic, load/clear inputs and `rst` handling. Instantiated twice.
- The top-level module holds the arbiter, the output stage, the hazard compare and the counter.

## Test plan
- Reset, then source 1 only writes addr 5, data 0xDEADBEEF → after two cycles `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`, then `rf_we=0`.
- Both sources valid in the same cycle, addr 3/0x11 and addr 4/0x22:
  - Fixed priority → writes addr 3 then addr 4 on consecutive cycles, `s1_ready=0` for 1 cycle, and `conflict_cnt=1`.
- Both sources stream 4 writes each, back-to-back:
  - With `WB_ARB_RR_EN` → grants alternate 0,1,0,1…
  - Without it → all four source-0 writes first.
- Source 0 writes addr 0, data 0xFFFFFFFF → handshake completes, `rf_we` never rises, and `q_hit1` with `q_addr1=0` stays 0.
- Source 0 write to addr 7 in flight; `q_addr1=7` → `q_hit1=1` from the acceptance edge through the cycle where `rf_we=1`, and 0 on the following cycle.
- Both slots full, assert `rst` for one cycle → no `rf_we` pulse, readies are 0 during reset, slots are empty afterwards and `conflict_cnt=0`.
